// File: rtl/combination_keypad_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// combination_keypad_conditioner_pkg
// Shared definitions for the keypad conditioner:
//   - chan_state_t : per-button debounce FSM state encoding
//   - cnt_width()  : counter width needed to hold a cycle count (minimum 1)
// ---------------------------------------------------------------------------
package combination_keypad_conditioner_pkg;

    // Per-channel debounce state; encoding fixed so waveforms read the same
    // in every build.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } chan_state_t;

    // Bits needed to represent 0..cycles; never returns less than 1.
    function automatic int cnt_width(input int cycles);
        int w;
        if (cycles < 1) begin
            w = 1;
        end else begin
            w = $clog2(cycles + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/combination_keypad_conditioner_button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// One keypad channel: 2-flop synchroniser, debounce FSM and saturating
// stability counter. press_evt pulses for one cycle on the clock edge where
// a press is accepted; a held key never re-fires.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   btn_raw   : raw, bouncy, asynchronous button level (active-high)
//   press_evt : one-cycle press acceptance (combinational from FSM state)
// ---------------------------------------------------------------------------
module button_debounce
    import combination_keypad_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_evt
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic        sync_meta_r;
    logic        sync_q_r;
    chan_state_t state_r;
    chan_state_t state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    // Two-flop synchroniser; only sync_q_r is consumed downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta_r <= 1'b0;
            sync_q_r    <= 1'b0;
        end else begin
            sync_meta_r <= btn_raw;
            sync_q_r    <= sync_meta_r;
        end
    end

    // Debounce FSM state and stability counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RELEASED;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state, counter update and press event. The counter only
    // increments below CNT_MAX, so it saturates instead of wrapping.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        press_evt = 1'b0;
        case (state_r)
            RELEASED: begin
                if (sync_q_r) begin
                    state_s = PRESS_WAIT;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (!sync_q_r) begin
                    state_s = RELEASED;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r >= CNT_MAX) begin
                    state_s   = PRESSED;
                    cnt_s     = CNT_ZERO;
                    press_evt = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync_q_r) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            RELEASE_WAIT: begin
                if (sync_q_r) begin
                    state_s = PRESSED;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r >= CNT_MAX) begin
                    state_s = RELEASED;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = RELEASED;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/combination_keypad_conditioner.sv
// ---------------------------------------------------------------------------
// combination_keypad_conditioner
// Conditions the ZERO and ONE push-buttons for the combination-lock FSM:
// synchronise, debounce, edge-detect, then arbitrate so that at most one
// clean single-cycle strobe per physical press reaches the lock. Presses
// accepted on the same edge are both suppressed and flagged as a conflict.
//
// Optional feature (macro KEYPAD_INTER_KEY_TIMEOUT_EN): an inter-key timer
// restarted by every zero/one/conflict strobe; TIMEOUT_CYCLES cycles after
// the last strobe it pulses key_timeout once. Without the macro key_timeout
// is tied low and TIMEOUT_CYCLES has no effect.
//
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   btn_zero_raw : raw ZERO button level (async, active-high)
//   btn_one_raw  : raw ONE button level (async, active-high)
//   zero         : registered strobe, accepted ZERO press
//   one          : registered strobe, accepted ONE press
//   conflict     : registered strobe, both presses on the same edge
//   key_timeout  : registered strobe, inter-key timeout (feature only)
// ---------------------------------------------------------------------------
module combination_keypad_conditioner
    import combination_keypad_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_zero_raw,
    input  logic btn_one_raw,
    output logic zero,
    output logic one,
    output logic conflict,
    output logic key_timeout
);

    // Reject parameter values the debounce and timeout logic cannot honour.
    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("combination_keypad_conditioner: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    logic zero_evt_s;
    logic one_evt_s;
    logic zero_r;
    logic one_r;
    logic conflict_r;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_zero_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_zero_raw),
        .press_evt (zero_evt_s)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_one_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_one_raw),
        .press_evt (one_evt_s)
    );

    // Arbitration: a lone event passes, same-edge events become a conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_r     <= 1'b0;
            one_r      <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            zero_r     <= zero_evt_s & ~one_evt_s;
            one_r      <= one_evt_s & ~zero_evt_s;
            conflict_r <= zero_evt_s & one_evt_s;
        end
    end

    assign zero     = zero_r;
    assign one      = one_r;
    assign conflict = conflict_r;

`ifdef KEYPAD_INTER_KEY_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_r;
    logic          to_armed_r;
    logic          key_timeout_r;
    logic          any_evt_s;

    // Any event that will produce a strobe this edge restarts the timer, so
    // the count stays aligned with the strobe cycle and beats a coincident
    // expiry.
    assign any_evt_s = zero_evt_s | one_evt_s;

    // Inter-key timer: counts from the last strobe, fires once, then idles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r      <= TO_ZERO;
            to_armed_r    <= 1'b0;
            key_timeout_r <= 1'b0;
        end else if (any_evt_s) begin
            to_cnt_r      <= TO_ZERO;
            to_armed_r    <= 1'b1;
            key_timeout_r <= 1'b0;
        end else if (to_armed_r && (to_cnt_r == TO_LAST)) begin
            to_cnt_r      <= to_cnt_r + TO_ONE;
            to_armed_r    <= 1'b0;
            key_timeout_r <= 1'b1;
        end else if (to_armed_r) begin
            to_cnt_r      <= to_cnt_r + TO_ONE;
            to_armed_r    <= 1'b1;
            key_timeout_r <= 1'b0;
        end else begin
            to_cnt_r      <= to_cnt_r;
            to_armed_r    <= 1'b0;
            key_timeout_r <= 1'b0;
        end
    end

    assign key_timeout = key_timeout_r;
`else
    assign key_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_combination_keypad_conditioner.sv
// ---------------------------------------------------------------------------
// tb_combination_keypad_conditioner
// Directed test-plan scenarios followed by randomized button activity. A
// run-length reference model predicts, per clock edge, which strobes the
// conditioner must raise; predictions go into a queue and a separate
// monitor pops and compares them on every cycle where the DUT or the model
// shows activity. Define KEYPAD_INTER_KEY_TIMEOUT_EN to also model the
// inter-key timeout.
// ---------------------------------------------------------------------------
module tb_combination_keypad_conditioner;

    localparam int DEB = 4;
    localparam int TO  = 20;

    logic clk = 1'b0;
    logic rst;
    logic bz;
    logic bo;
    logic zero;
    logic one;
    logic conflict;
    logic key_timeout;

    combination_keypad_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_zero_raw (bz),
        .btn_one_raw  (bo),
        .zero         (zero),
        .one          (one),
        .conflict     (conflict),
        .key_timeout  (key_timeout)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising clock edge.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         edge_no;
        logic [3:0] mask;   // {key_timeout, conflict, one, zero}
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state: two-sample delay per button, accepted level
    // and length of the current run of samples disagreeing with it.
    bit [1:0] sq1;
    bit [1:0] sq2;
    bit [1:0] lvl;
    int       run [2];
    bit       to_armed;
    int       last_strobe;

    task automatic model_reset();
        sq1 = 2'b00;
        sq2 = 2'b00;
        lvl = 2'b00;
        run[0] = 0;
        run[1] = 0;
        to_armed = 1'b0;
        last_strobe = 0;
    endtask

    // Predict the outputs registered on edge k given the raw levels that
    // edge samples. A level change is accepted after DEB+1 consecutive
    // disagreeing synchronised samples; accepting a 1 is a press.
    task automatic model_step(input bit r0, input bit r1, input int k);
        bit [1:0]   evt;
        bit [1:0]   raw;
        logic [3:0] m;
        raw = {r1, r0};
        evt = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (sq2[c] != lvl[c]) begin
                run[c] = run[c] + 1;
                if (run[c] == DEB + 1) begin
                    lvl[c] = sq2[c];
                    run[c] = 0;
                    evt[c] = sq2[c];
                end
            end else begin
                run[c] = 0;
            end
        end
        sq2 = sq1;
        sq1 = raw;
        m = 4'b0000;
        if (evt == 2'b11) m[2] = 1'b1;
        else if (evt[0]) m[0] = 1'b1;
        else if (evt[1]) m[1] = 1'b1;
`ifdef KEYPAD_INTER_KEY_TIMEOUT_EN
        if (m != 4'b0000) begin
            to_armed = 1'b1;
            last_strobe = k;
        end else if (to_armed && (k == last_strobe + TO)) begin
            m[3] = 1'b1;
            to_armed = 1'b0;
        end
`endif
        if (m != 4'b0000) exp_q.push_back('{k, m});
    endtask

    // Monitor: compare DUT strobes against the queued predictions.
    always @(negedge clk) begin
        logic [3:0] act;
        logic [3:0] expm;
        int         cur;
        cur  = edge_cnt;
        act  = {key_timeout, conflict, one, zero};
        expm = 4'b0000;
        while (exp_q.size() > 0 && exp_q[0].edge_no < cur) begin
            n_total = n_total + 1;
            $display("FAIL missed_strobe edge %0d: got nothing, expected %b", exp_q[0].edge_no, exp_q[0].mask);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].edge_no == cur) begin
            expm = exp_q[0].mask;
            void'(exp_q.pop_front());
        end
        if (act != 4'b0000 || expm != 4'b0000) begin
            n_total = n_total + 1;
            if (act === expm) n_pass = n_pass + 1;
            else $display("FAIL strobe edge %0d: got {to,cf,one,zero}=%b, expected %b", cur, act, expm);
        end
    end

    // Apply raw levels for the next edge and predict its outputs.
    task automatic drive_cycle(input bit b0, input bit b1);
        @(negedge clk);
        #1;
        bz = b0;
        bo = b1;
        model_step(b0, b1, edge_cnt + 1);
    endtask

    task automatic hold(input bit b0, input bit b1, input int n);
        for (int i = 0; i < n; i++) drive_cycle(b0, b1);
    endtask

    task automatic check_outputs_low(input string name);
        n_total = n_total + 1;
        if ({key_timeout, conflict, one, zero} === 4'b0000) n_pass = n_pass + 1;
        else $display("FAIL %s: got {to,cf,one,zero}=%b, expected 0000", name, {key_timeout, conflict, one, zero});
    endtask

    // Asynchronous reset mid-cycle, held for hold_edges edges; raw levels
    // stay as they were so a held key is seen again after release.
    task automatic reset_pulse(input int hold_edges);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_outputs_low("async_reset");
        model_reset();
        repeat (hold_edges) @(negedge clk);
        #1;
        rst = 1'b1;
        model_step(bz, bo, edge_cnt + 1);
    endtask

    initial begin
        bit r0;
        bit r1;
        int len;
        int mode0;
        int mode1;
        rst = 1'b0;
        bz  = 1'b0;
        bo  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs_low("reset_state");
        rst = 1'b1;
        model_step(1'b0, 1'b0, edge_cnt + 1);

        hold(1'b0, 1'b0, 5);
        // Clean ZERO press held 30 cycles.
        hold(1'b1, 1'b0, 30);
        hold(1'b0, 1'b0, 10);
        // Bouncy ONE press, then bouncy release.
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, (i % 2) == 0);
        hold(1'b0, 1'b1, 15);
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0);
        hold(1'b0, 1'b0, 10);
        // Simultaneous press.
        hold(1'b1, 1'b1, 12);
        hold(1'b0, 1'b0, 10);
        // Overlap: ZERO held, ONE pressed 10 cycles later.
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 15);
        hold(1'b0, 1'b0, 10);
        // Reset in the very cycle the ZERO strobe is high; key stays held.
        hold(1'b1, 1'b0, 7);
        reset_pulse(3);
        hold(1'b1, 1'b0, 12);
        hold(1'b0, 1'b0, 10);
        // Reset during PRESS_WAIT of ONE; key stays held.
        hold(1'b0, 1'b1, 3);
        reset_pulse(2);
        hold(1'b0, 1'b1, 12);
        hold(1'b0, 1'b0, 30);
        // Timeout after idle, then a second press landing 19 cycles after
        // the strobe that restarts the timer.
        hold(1'b1, 1'b0, 8);
        hold(1'b0, 1'b0, 30);
        hold(1'b1, 1'b0, 8);
        hold(1'b0, 1'b0, 11);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 30);

        // Randomized segments: each button low, high, bouncing or unchanged.
        r0 = 1'b0;
        r1 = 1'b0;
        for (int s = 0; s < 60; s++) begin
            len   = $urandom_range(1, 25);
            mode0 = $urandom_range(0, 3);
            mode1 = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                if (mode0 == 0) r0 = 1'b0;
                else if (mode0 == 1) r0 = 1'b1;
                else if (mode0 == 2) r0 = 1'($urandom_range(0, 1));
                if (mode1 == 0) r1 = 1'b0;
                else if (mode1 == 1) r1 = 1'b1;
                else if (mode1 == 2) r1 = 1'($urandom_range(0, 1));
                drive_cycle(r0, r1);
            end
            if (s == 30) reset_pulse(2);
        end
        hold(1'b0, 1'b0, 40);

        @(negedge clk);
        #1;
        n_total = n_total + 1;
        if (exp_q.size() == 0) n_pass = n_pass + 1;
        else $display("FAIL pending_predictions: got %0d left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
